// File: rtl/full_adder_pkg.sv
// ============================================================================
// full_adder_pkg : shared width limit and reference add for the ripple adder
// Revision 1.0
// ============================================================================
`default_nettype none

package full_adder_pkg;

  localparam int MAX_WIDTH = 64;

  // Returns {cout, sum} at MAX_WIDTH+1 bits; narrower callers take the low WIDTH+1 bits.
  function automatic logic [MAX_WIDTH:0] add_ref(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 cin
  );
    return {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// ============================================================================
// full_adder_cell : 1-bit combinational full-adder cell
// Revision 1.0
// ============================================================================
`default_nettype none

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// full_adder : WIDTH-bit ripple-carry adder with optional output register
// Revision 1.0
// ============================================================================
`default_nettype none

module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("full_adder: WIDTH must be within 1..MAX_WIDTH");
  end

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (w_c[i]),
      .s  (w_sum[i]),
      .co (w_c[i+1])
    );
  end

  assign w_cout = w_c[WIDTH];
  assign w_ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];

  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_valid;

    // Result registers load only on valid cycles so idle inputs never disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum   <= '0;
        r_cout  <= 1'b0;
        r_ovf   <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_sum  <= w_sum;
          r_cout <= w_cout;
          r_ovf  <= w_ovf;
        end
      end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign out_valid = r_valid;
  end else begin : g_comb
    logic w_unused;

    assign w_unused  = &{1'b0, clk, rst_n};
    assign sum       = w_sum;
    assign cout      = w_cout;
    assign ovf       = w_ovf;
    assign out_valid = in_valid;
  end

endmodule

`default_nettype wire

// File: tb/tb_full_adder.sv
// ============================================================================
// tb_full_adder : vector tables, corner sequences and random checks for full_adder
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a1, b1, c1, v1, s1, co1, ov1, ovl1;
  logic [3:0] a4, b4, s4;
  logic       c4, v4, co4, ov4, ovl4;
  logic [7:0] a8, b8, s8;
  logic       c8, v8, co8, ov8, ovl8;

  int n_checks = 0;
  int n_err    = 0;

  full_adder #(.WIDTH(1), .REG_OUT(0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .cin(c1), .in_valid(v1),
    .sum(s1), .cout(co1), .ovf(ov1), .out_valid(ovl1)
  );

  full_adder #(.WIDTH(4), .REG_OUT(1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .cin(c4), .in_valid(v4),
    .sum(s4), .cout(co4), .ovf(ov4), .out_valid(ovl4)
  );

  full_adder #(.WIDTH(8), .REG_OUT(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .cin(c8), .in_valid(v8),
    .sum(s8), .cout(co8), .ovf(ov8), .out_valid(ovl8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t t1[8];
  vec_t t4[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_w4(input string name, input logic [3:0] es, input logic ec,
                        input logic eo, input logic ev);
    chk({name, "_sum"},   64'(s4),   64'(es));
    chk({name, "_cout"},  64'(co4),  64'(ec));
    chk({name, "_ovf"},   64'(ov4),  64'(eo));
    chk({name, "_valid"}, 64'(ovl4), 64'(ev));
  endtask

  // Reference: unsigned sum at 9 bits, overflow from signed range of the operands.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    int unsigned u;
    int          sa, sb, ss;
    logic [9:0]  r;
    u  = int'(a) + int'(b) + int'(ci);
    sa = a[7] ? int'(a) - 256 : int'(a);
    sb = b[7] ? int'(b) - 256 : int'(b);
    ss = sa + sb + int'(ci);
    r[8:0] = u[8:0];
    r[9]   = (ss > 127) || (ss < -128);
    return r;
  endfunction

  initial begin
    logic [9:0] exp8;
    logic [9:0] prev8;

    t1[0] = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    t1[1] = '{4'd0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b1};
    t1[2] = '{4'd0, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0};
    t1[3] = '{4'd0, 4'd1, 1'b1, 4'd0, 1'b1, 1'b0};
    t1[4] = '{4'd1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0};
    t1[5] = '{4'd1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0};
    t1[6] = '{4'd1, 4'd1, 1'b0, 4'd0, 1'b1, 1'b1};
    t1[7] = '{4'd1, 4'd1, 1'b1, 4'd1, 1'b1, 1'b0};
    t4[0] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
    t4[1] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
    t4[2] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};

    rst_n = 1'b0;
    a1 = 0; b1 = 0; c1 = 0; v1 = 0;
    a4 = 0; b4 = 0; c4 = 0; v4 = 0;
    a8 = 0; b8 = 0; c8 = 0; v8 = 0;

    #3;
    chk_w4("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("reset_w8_valid", 64'(ovl8), 64'd0);

    // Combinational single-bit adder, exhaustive.
    for (int i = 0; i < 8; i++) begin
      a1 = t1[i].a[0]; b1 = t1[i].b[0]; c1 = t1[i].cin; v1 = i[0];
      #1;
      chk($sformatf("w1_sum_%0d", i),   64'(s1),   64'(t1[i].sum[0]));
      chk($sformatf("w1_cout_%0d", i),  64'(co1),  64'(t1[i].cout));
      chk($sformatf("w1_ovf_%0d", i),   64'(ov1),  64'(t1[i].ovf));
      chk($sformatf("w1_valid_%0d", i), 64'(ovl1), 64'(i[0]));
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Registered 4-bit corner vectors, one edge of latency each.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a4 = t4[i].a; b4 = t4[i].b; c4 = t4[i].cin; v4 = 1'b1;
      @(posedge clk); #1;
      chk_w4($sformatf("w4_vec%0d", i), t4[i].sum, t4[i].cout, t4[i].ovf, 1'b1);
    end

    // Load 3+4, then idle with garbage inputs: result must hold.
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd4; c4 = 1'b0; v4 = 1'b1;
    @(posedge clk); #1;
    chk_w4("hold_load", 4'h7, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      v4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      @(posedge clk); #1;
      chk_w4($sformatf("hold_idle%0d", k), 4'h7, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset between edges, then first valid input after release.
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd6; c4 = 1'b0; v4 = 1'b1;
    @(posedge clk); #1;
    chk_w4("pre_reset", 4'hB, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_w4("async_reset", 4'h0, 1'b0, 1'b0, 1'b0);
    a4 = 4'd2; b4 = 4'd3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_w4("post_release", 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_w4("first_after_reset", 4'h5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    v4 = 1'b0;

    // Random back-to-back 8-bit adds; outputs must trail inputs by one edge.
    prev8 = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(0, 1)); v8 = 1'b1;
      exp8 = model8(a8, b8, c8);
      #1;
      if (i > 0)
        chk("w8_latency", 64'({ov8, co8, s8}), 64'(prev8));
      @(posedge clk); #1;
      chk("w8_result", 64'({ov8, co8, s8}), 64'(exp8));
      chk("w8_valid",  64'(ovl8), 64'd1);
      prev8 = exp8;
    end
    @(negedge clk);
    v8 = 1'b0;
    @(posedge clk); #1;
    chk("w8_valid_drop", 64'(ovl8), 64'd0);
    chk("w8_hold", 64'({ov8, co8, s8}), 64'(prev8));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
